// File: rtl/spram_rd_verify_pkg.sv
// Shared definitions for the single-port RAM verifier and its write-side partner.
// The default geometry and the expected-pattern function keep both ends in agreement.
package spram_rd_verify_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FIN   = 2'd3
  } state_t;

  localparam int DEF_ADDR_W = 5;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 32;
  localparam int DEF_RD_LAT = 2;

  // Callers truncate the result to their data width, giving the modulo- 2^DATA_W wrap.
  function automatic logic [31:0] exp_data(input logic [31:0] base, input logic [31:0] addr);
    return base + addr;
  endfunction

endpackage

// File: rtl/spram_rd_pipe.sv
// RD_LAT-deep {valid, addr} delay line that lines each issued read up with its RAM data.
// The pending flag covers every stage except the tail, which is consumed in the current cycle.
module spram_rd_pipe #(
  parameter int ADDR_W = 5,
  parameter int RD_LAT = 2
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] in_addr,
  output logic              tail_valid,
  output logic [ADDR_W-1:0] tail_addr,
  output logic              pending
);

  logic [RD_LAT-1:0] vld;
  logic [ADDR_W-1:0] adr [RD_LAT];

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      vld <= '0;
      for (int i = 0; i < RD_LAT; i++) adr[i] <= '0;
    end else begin
      vld[0] <= in_valid;
      adr[0] <= in_addr;
      for (int i = 1; i < RD_LAT; i++) begin
        vld[i] <= vld[i-1];
        adr[i] <= adr[i-1];
      end
    end
  end

  always_comb begin
    pending = 1'b0;
    for (int i = 0; i < RD_LAT - 1; i++) pending = pending | vld[i];
  end

  assign tail_valid = vld[RD_LAT-1];
  assign tail_addr  = adr[RD_LAT-1];

endmodule

// File: rtl/spram_rd_verify.sv
// Read-side verifier: sweeps the RAM once per start, compares against the incrementing
// pattern and reports pass, mismatch count and first failing address.
//
// state    | meaning
// ST_IDLE  | waiting for start; results held from the last sweep
// ST_READ  | one read per cycle, addresses 0..DEPTH-1
// ST_DRAIN | reads issued, waiting for outstanding results
// ST_FIN   | last compare done; pulse done and publish pass
module spram_rd_verify
  import spram_rd_verify_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int RD_LAT    = DEF_RD_LAT,
  parameter int DATA_BASE = 0
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              start,
  output logic              ram_rd_en,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_rd_data,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W:0]   err_cnt,
  output logic [ADDR_W-1:0] err_addr
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   CNT_MAX   = (ADDR_W+1)'(DEPTH);

  state_t            state, state_nxt;
  logic              first_err;
  logic              tail_valid;
  logic [ADDR_W-1:0] tail_addr;
  logic              pending;
  logic [DATA_W-1:0] exp_word;
  logic              mismatch;

  spram_rd_pipe #(
    .ADDR_W (ADDR_W),
    .RD_LAT (RD_LAT)
  ) u_pipe (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .in_valid   (ram_rd_en),
    .in_addr    (ram_addr),
    .tail_valid (tail_valid),
    .tail_addr  (tail_addr),
    .pending    (pending)
  );

  assign exp_word = DATA_W'(exp_data(32'(DATA_BASE), 32'(tail_addr)));
  assign mismatch = tail_valid && (ram_rd_data != exp_word);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= ST_IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_READ;
      ST_READ:  if (ram_addr == LAST_ADDR) state_nxt = ST_DRAIN;
      // The tail entry is compared on this edge, so only earlier stages keep us here.
      ST_DRAIN: if (!pending) state_nxt = ST_FIN;
      ST_FIN:   state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      ram_rd_en <= 1'b0;
      ram_addr  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_cnt   <= '0;
      err_addr  <= '0;
      first_err <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            busy      <= 1'b1;
            ram_addr  <= '0;
            ram_rd_en <= 1'b1;
            err_cnt   <= '0;
            err_addr  <= '0;
            pass      <= 1'b0;
            first_err <= 1'b0;
          end
        end
        ST_READ: begin
          if (ram_addr == LAST_ADDR) ram_rd_en <= 1'b0;
          else                       ram_addr  <= ram_addr + 1'b1;
        end
        ST_FIN: begin
          done <= 1'b1;
          busy <= 1'b0;
          pass <= (err_cnt == '0);
        end
        default: ;
      endcase

      if (mismatch) begin
        if (err_cnt != CNT_MAX) err_cnt <= err_cnt + 1'b1;
        if (!first_err) begin
          err_addr  <= tail_addr;
          first_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_spram_rd_verify.sv
// Scoreboard bench for spram_rd_verify: directed sweeps push expected results, and
// per-instance monitors pop and compare on every done pulse.
module tb_spram_rd_verify;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_a, start_b;
  logic       rd_en_a, rd_en_b;
  logic [4:0] addr_a, addr_b;
  logic [7:0] q_a, q_b;
  logic       busy_a, busy_b, done_a, done_b, pass_a, pass_b;
  logic [5:0] cnt_a, cnt_b;
  logic [4:0] eaddr_a, eaddr_b;

  logic [7:0] mem_a [32];
  logic [7:0] mem_b [32];
  logic [4:0] ar_a, ar_b;

  typedef struct packed {
    logic       pass;
    logic [5:0] cnt;
    logic [4:0] adr;
  } exp_t;

  exp_t sb_a[$];
  exp_t sb_b[$];
  exp_t e_a, e_b;

  int checks = 0;
  int errors = 0;
  int busy_cyc_a = 0, rd_cyc_a = 0, busy_cyc_b = 0, rd_cyc_b = 0;

  always #10 clk = ~clk;

  spram_rd_verify #(.DATA_BASE(0)) dut_a (
    .sys_clk(clk), .sys_rst_n(rst_n), .start(start_a),
    .ram_rd_en(rd_en_a), .ram_addr(addr_a), .ram_rd_data(q_a),
    .busy(busy_a), .done(done_a), .pass(pass_a),
    .err_cnt(cnt_a), .err_addr(eaddr_a)
  );

  spram_rd_verify #(.DATA_BASE(250)) dut_b (
    .sys_clk(clk), .sys_rst_n(rst_n), .start(start_b),
    .ram_rd_en(rd_en_b), .ram_addr(addr_b), .ram_rd_data(q_b),
    .busy(busy_b), .done(done_b), .pass(pass_b),
    .err_cnt(cnt_b), .err_addr(eaddr_b)
  );

  // Two-cycle RAM: registered address, then registered output.
  always @(posedge clk) begin
    ar_a <= addr_a;
    q_a  <= mem_a[ar_a];
    ar_b <= addr_b;
    q_b  <= mem_b[ar_b];
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      busy_cyc_a = 0;
      rd_cyc_a   = 0;
    end else begin
      if (busy_a)  busy_cyc_a++;
      if (rd_en_a) rd_cyc_a++;
      if (done_a) begin
        chk("a_done_expected", (sb_a.size() > 0) ? 1 : 0, 1);
        if (sb_a.size() > 0) begin
          e_a = sb_a.pop_front();
          chk("a_pass", int'(pass_a), int'(e_a.pass));
          chk("a_err_cnt", int'(cnt_a), int'(e_a.cnt));
          chk("a_err_addr", int'(eaddr_a), int'(e_a.adr));
          chk("a_busy_cycles", busy_cyc_a, 35);
          chk("a_read_cycles", rd_cyc_a, 32);
        end
        busy_cyc_a = 0;
        rd_cyc_a   = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      busy_cyc_b = 0;
      rd_cyc_b   = 0;
    end else begin
      if (busy_b)  busy_cyc_b++;
      if (rd_en_b) rd_cyc_b++;
      if (done_b) begin
        chk("b_done_expected", (sb_b.size() > 0) ? 1 : 0, 1);
        if (sb_b.size() > 0) begin
          e_b = sb_b.pop_front();
          chk("b_pass", int'(pass_b), int'(e_b.pass));
          chk("b_err_cnt", int'(cnt_b), int'(e_b.cnt));
          chk("b_err_addr", int'(eaddr_b), int'(e_b.adr));
          chk("b_busy_cycles", busy_cyc_b, 35);
          chk("b_read_cycles", rd_cyc_b, 32);
        end
        busy_cyc_b = 0;
        rd_cyc_b   = 0;
      end
    end
  end

  task automatic chk_reset_a(input string tag);
    chk({tag, "_rd_en"}, int'(rd_en_a), 0);
    chk({tag, "_addr"}, int'(addr_a), 0);
    chk({tag, "_busy"}, int'(busy_a), 0);
    chk({tag, "_done"}, int'(done_a), 0);
    chk({tag, "_pass"}, int'(pass_a), 0);
    chk({tag, "_err_cnt"}, int'(cnt_a), 0);
    chk({tag, "_err_addr"}, int'(eaddr_a), 0);
  endtask

  task automatic pulse_a();
    @(negedge clk) start_a = 1'b1;
    @(negedge clk) start_a = 1'b0;
  endtask

  task automatic wait_done_a(input string name);
    int n = 0;
    while (!done_a && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk({name, "_timeout"}, 0, 1);
    @(negedge clk);
  endtask

  task automatic sweep_a(input string name, input logic p, input int cnt, input int adr);
    sb_a.push_back('{pass: p, cnt: 6'(cnt), adr: 5'(adr)});
    pulse_a();
    wait_done_a(name);
  endtask

  task automatic fill_a();
    for (int i = 0; i < 32; i++) mem_a[i] = 8'(i);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n   = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    fill_a();
    for (int i = 0; i < 32; i++) mem_b[i] = 8'(250 + i);
    #35;
    chk_reset_a("reset");
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Clean pattern, then pass must hold while idle.
    sweep_a("clean", 1'b1, 0, 0);
    repeat (5) @(negedge clk);
    chk("pass_held", int'(pass_a), 1);

    // Two corrupted words; only the first address is reported.
    mem_a[7]  = 8'h87;
    mem_a[20] = 8'h55;
    sweep_a("two_err", 1'b0, 2, 7);
    fill_a();

    // Base 250 wraps through zero at address 6.
    sb_b.push_back('{pass: 1'b1, cnt: 6'd0, adr: 5'd0});
    @(negedge clk) start_b = 1'b1;
    @(negedge clk) start_b = 1'b0;
    begin
      int n = 0;
      while (!done_b && n < 100) begin
        @(negedge clk);
        n++;
      end
      if (n >= 100) chk("wrap_timeout", 0, 1);
    end
    @(negedge clk);

    // Start at cycle 10 of a sweep and again during FIN: both ignored.
    sb_a.push_back('{pass: 1'b1, cnt: 6'd0, adr: 5'd0});
    pulse_a();
    repeat (9) @(negedge clk);
    start_a = 1'b1;
    @(negedge clk) start_a = 1'b0;
    repeat (24) @(negedge clk);
    start_a = 1'b1;
    @(negedge clk) start_a = 1'b0;
    repeat (45) @(negedge clk);
    chk("restart_ignored_sb", sb_a.size(), 0);
    chk("restart_idle_busy", int'(busy_a), 0);

    // Reset at cycle 15 of a sweep: immediate clear, no done.
    pulse_a();
    repeat (14) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_reset_a("midreset");
    @(negedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (45) @(negedge clk);
    chk("midreset_no_busy", int'(busy_a), 0);
    sweep_a("after_reset", 1'b1, 0, 0);

    // Every word wrong, then only the last word wrong.
    for (int i = 0; i < 32; i++) mem_a[i] = ~8'(i);
    sweep_a("all_wrong", 1'b0, 32, 0);
    fill_a();
    mem_a[31] = 8'h00;
    sweep_a("last_wrong", 1'b0, 1, 31);

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", sb_a.size() + sb_b.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
